// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage of the pipelined RV32I core. Owns the program
// counter, drives the instruction-memory address and registers the fetched
// instruction, its PC and PC+4 into the IF/ID boundary for the decoder.
//
// Ports:
//   clk        core clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   StallF     hazard unit: hold PC and IF/ID contents
//   PCSrcE     taken branch/jump resolved in EX: redirect fetch
//   PCTargetE  redirect target address
//   ImemAddr   instruction-memory address (equals PCF)
//   ImemRdata  instruction word, combinational read of ImemAddr
//   PCF        current fetch PC
//   InstrD     registered instruction to decode
//   PCD        PC of InstrD
//   PCPlus4D   PCD + 4
//   ValidD     InstrD is a real fetched instruction (0 = bubble)
//   MisalignD  sticky: some redirect target had bits [1:0] != 0
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int              DATA_WIDTH   = 32,
    parameter int              ADDR_WIDTH   = 32,
    parameter logic [31:0]     RESET_PC     = 32'h00000000,
    parameter logic [31:0]     BUBBLE_INSTR = 32'h00000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  StallF,
    input  logic                  PCSrcE,
    input  logic [ADDR_WIDTH-1:0] PCTargetE,
    output logic [ADDR_WIDTH-1:0] ImemAddr,
    input  logic [DATA_WIDTH-1:0] ImemRdata,
    output logic [ADDR_WIDTH-1:0] PCF,
    output logic [DATA_WIDTH-1:0] InstrD,
    output logic [ADDR_WIDTH-1:0] PCD,
    output logic [ADDR_WIDTH-1:0] PCPlus4D,
    output logic                  ValidD,
    output logic                  MisalignD
);

    localparam logic [ADDR_WIDTH-1:0] RESET_PC_W     = RESET_PC[ADDR_WIDTH-1:0];
    localparam logic [DATA_WIDTH-1:0] BUBBLE_INSTR_W = BUBBLE_INSTR[DATA_WIDTH-1:0];
    localparam logic [ADDR_WIDTH-1:0] FOUR           = ADDR_WIDTH'(4);

    logic [ADDR_WIDTH-1:0] pcf_q,      pcf_d;
    logic [DATA_WIDTH-1:0] instr_q,    instr_d;
    logic [ADDR_WIDTH-1:0] pcd_q,      pcd_d;
    logic [ADDR_WIDTH-1:0] pcplus4d_q, pcplus4d_d;
    logic                  valid_q,    valid_d;
    logic                  misalign_q, misalign_d;

    // Wraps modulo 2^ADDR_WIDTH by construction; no overflow flag.
    logic [ADDR_WIDTH-1:0] pcplus4f;
    assign pcplus4f = pcf_q + FOUR;

    always_comb begin
        pcf_d      = pcf_q;
        instr_d    = instr_q;
        pcd_d      = pcd_q;
        pcplus4d_d = pcplus4d_q;
        valid_d    = valid_q;
        misalign_d = misalign_q;

        if (PCSrcE) begin
            // Redirect beats stall: the instruction fetched this cycle is
            // wrong-path, so a bubble goes into IF/ID instead. PCD/PCPlus4D
            // are left alone since ValidD=0 already marks the slot empty.
            pcf_d   = {PCTargetE[ADDR_WIDTH-1:2], 2'b00};
            instr_d = BUBBLE_INSTR_W;
            valid_d = 1'b0;
            if (PCTargetE[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else if (!StallF) begin
            pcf_d      = pcplus4f;
            instr_d    = ImemRdata;
            pcd_d      = pcf_q;
            pcplus4d_d = pcplus4f;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcf_q      <= RESET_PC_W;
            instr_q    <= BUBBLE_INSTR_W;
            pcd_q      <= '0;
            pcplus4d_q <= '0;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            pcf_q      <= pcf_d;
            instr_q    <= instr_d;
            pcd_q      <= pcd_d;
            pcplus4d_q <= pcplus4d_d;
            valid_q    <= valid_d;
            misalign_q <= misalign_d;
        end
    end

    assign ImemAddr  = pcf_q;
    assign PCF       = pcf_q;
    assign InstrD    = instr_q;
    assign PCD       = pcd_q;
    assign PCPlus4D  = pcplus4d_q;
    assign ValidD    = valid_q;
    assign MisalignD = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed bench for fetch_stage. Instruction memory returns
// 32'h00100093 + word_index for every address.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        StallF;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] ImemAddr;
    logic [31:0] ImemRdata;
    logic [31:0] PCF;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic        MisalignD;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign ImemRdata = 32'h00100093 + {2'b00, ImemAddr[31:2]};

    fetch_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .StallF    (StallF),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .ImemAddr  (ImemAddr),
        .ImemRdata (ImemRdata),
        .PCF       (PCF),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD),
        .MisalignD (MisalignD)
    );

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
        step(); step();
        checks++; if (PCF !== 32'h0) begin errors++; $display("FAIL reset_pcf got=%h exp=%h", PCF, 32'h0); end
        checks++; if (InstrD !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=%h", InstrD, 32'h0); end
        checks++; if (PCD !== 32'h0 || PCPlus4D !== 32'h0) begin errors++; $display("FAIL reset_pcd got=%h/%h exp=0/0", PCD, PCPlus4D); end
        checks++; if (ValidD !== 1'b0 || MisalignD !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", ValidD, MisalignD); end
        checks++; if (ImemAddr !== 32'h0) begin errors++; $display("FAIL reset_imemaddr got=%h exp=%h", ImemAddr, 32'h0); end
        $display("reset: PCF=%h InstrD=%h ValidD=%b", PCF, InstrD, ValidD);
        rst_n = 1'b1;
    endtask

    task automatic test_run();
        step();
        checks++; if (PCF !== 32'h4) begin errors++; $display("FAIL run1_pcf got=%h exp=%h", PCF, 32'h4); end
        checks++; if (InstrD !== 32'h00100093 || PCD !== 32'h0) begin errors++; $display("FAIL run1_instr got=%h@%h exp=00100093@0", InstrD, PCD); end
        checks++; if (PCPlus4D !== 32'h4 || ValidD !== 1'b1) begin errors++; $display("FAIL run1_p4v got=%h/%b exp=4/1", PCPlus4D, ValidD); end
        $display("run: PCF=%h InstrD=%h PCD=%h", PCF, InstrD, PCD);
        step();
        checks++; if (PCF !== 32'h8) begin errors++; $display("FAIL run2_pcf got=%h exp=%h", PCF, 32'h8); end
        checks++; if (InstrD !== 32'h00100094 || PCD !== 32'h4 || ValidD !== 1'b1) begin errors++; $display("FAIL run2_instr got=%h@%h v=%b exp=00100094@4 v=1", InstrD, PCD, ValidD); end
        $display("run: PCF=%h InstrD=%h PCD=%h", PCF, InstrD, PCD);
    endtask

    task automatic test_stall();
        StallF = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (PCF !== 32'h8 || InstrD !== 32'h00100094 || PCD !== 32'h4 || PCPlus4D !== 32'h8 || ValidD !== 1'b1) begin
                errors++; $display("FAIL stall%0d got PCF=%h InstrD=%h PCD=%h P4=%h V=%b exp 8/00100094/4/8/1", i, PCF, InstrD, PCD, PCPlus4D, ValidD);
            end
            $display("stall: PCF=%h InstrD=%h PCD=%h", PCF, InstrD, PCD);
        end
        StallF = 1'b0;
        step();
        checks++; if (PCF !== 32'hC || InstrD !== 32'h00100095 || PCD !== 32'h8) begin
            errors++; $display("FAIL stall_resume got PCF=%h InstrD=%h PCD=%h exp C/00100095/8", PCF, InstrD, PCD);
        end
        $display("resume: PCF=%h InstrD=%h PCD=%h", PCF, InstrD, PCD);
    endtask

    task automatic test_redirect();
        PCSrcE = 1'b1; PCTargetE = 32'h40;
        step();
        PCSrcE = 1'b0;
        checks++; if (PCF !== 32'h40 || InstrD !== 32'h0 || ValidD !== 1'b0) begin
            errors++; $display("FAIL redir_bubble got PCF=%h InstrD=%h V=%b exp 40/0/0", PCF, InstrD, ValidD);
        end
        checks++; if (PCD !== 32'h8 || PCPlus4D !== 32'hC) begin errors++; $display("FAIL redir_hold got PCD=%h P4=%h exp 8/C", PCD, PCPlus4D); end
        $display("redirect: PCF=%h InstrD=%h V=%b", PCF, InstrD, ValidD);
        step();
        checks++; if (PCF !== 32'h44 || InstrD !== 32'h001000A3 || PCD !== 32'h40 || PCPlus4D !== 32'h44 || ValidD !== 1'b1) begin
            errors++; $display("FAIL redir_target got PCF=%h InstrD=%h PCD=%h P4=%h V=%b exp 44/001000A3/40/44/1", PCF, InstrD, PCD, PCPlus4D, ValidD);
        end
        $display("target: PCF=%h InstrD=%h PCD=%h", PCF, InstrD, PCD);
    endtask

    task automatic test_redirect_over_stall();
        PCSrcE = 1'b1; StallF = 1'b1; PCTargetE = 32'h80;
        step();
        PCSrcE = 1'b0; StallF = 1'b0;
        checks++; if (PCF !== 32'h80 || ValidD !== 1'b0 || InstrD !== 32'h0) begin
            errors++; $display("FAIL redir_stall got PCF=%h V=%b InstrD=%h exp 80/0/0", PCF, ValidD, InstrD);
        end
        $display("redirect+stall: PCF=%h V=%b", PCF, ValidD);
        step();
        checks++; if (PCF !== 32'h84 || InstrD !== 32'h001000B3 || ValidD !== 1'b1) begin
            errors++; $display("FAIL redir_stall_next got PCF=%h InstrD=%h V=%b exp 84/001000B3/1", PCF, InstrD, ValidD);
        end
    endtask

    task automatic test_back_to_back();
        PCSrcE = 1'b1; PCTargetE = 32'h100;
        step();
        checks++; if (PCF !== 32'h100 || ValidD !== 1'b0) begin errors++; $display("FAIL b2b_first got PCF=%h V=%b exp 100/0", PCF, ValidD); end
        PCTargetE = 32'h200;
        step();
        PCSrcE = 1'b0;
        checks++; if (PCF !== 32'h200 || ValidD !== 1'b0 || PCD !== 32'h80) begin errors++; $display("FAIL b2b_second got PCF=%h V=%b PCD=%h exp 200/0/80", PCF, ValidD, PCD); end
        $display("back-to-back: PCF=%h V=%b", PCF, ValidD);
        step();
        checks++; if (InstrD !== 32'h00100113 || PCD !== 32'h200 || ValidD !== 1'b1) begin
            errors++; $display("FAIL b2b_target got InstrD=%h PCD=%h V=%b exp 00100113/200/1", InstrD, PCD, ValidD);
        end
    endtask

    task automatic test_misalign();
        checks++; if (MisalignD !== 1'b0) begin errors++; $display("FAIL misalign_pre got=%b exp=0", MisalignD); end
        PCSrcE = 1'b1; PCTargetE = 32'h42;
        step();
        checks++; if (PCF !== 32'h40 || MisalignD !== 1'b1) begin errors++; $display("FAIL misalign_set got PCF=%h M=%b exp 40/1", PCF, MisalignD); end
        $display("misalign: PCF=%h M=%b", PCF, MisalignD);
        PCTargetE = 32'h1C;
        step();
        PCSrcE = 1'b0;
        step();
        checks++; if (MisalignD !== 1'b1 || PCF !== 32'h20 || InstrD !== 32'h0010009A) begin
            errors++; $display("FAIL misalign_sticky got M=%b PCF=%h InstrD=%h exp 1/20/0010009A", MisalignD, PCF, InstrD);
        end
    endtask

    task automatic test_async_reset();
        StallF = 1'b1;
        step();
        checks++; if (PCF !== 32'h20) begin errors++; $display("FAIL ares_pre got PCF=%h exp 20", PCF); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (PCF !== 32'h0 || InstrD !== 32'h0 || ValidD !== 1'b0 || MisalignD !== 1'b0) begin
            errors++; $display("FAIL async_reset got PCF=%h InstrD=%h V=%b M=%b exp 0/0/0/0", PCF, InstrD, ValidD, MisalignD);
        end
        $display("async reset: PCF=%h InstrD=%h V=%b", PCF, InstrD, ValidD);
        #1;
        rst_n = 1'b1; StallF = 1'b0;
        step();
        checks++; if (PCF !== 32'h4 || InstrD !== 32'h00100093 || ValidD !== 1'b1) begin
            errors++; $display("FAIL ares_release got PCF=%h InstrD=%h V=%b exp 4/00100093/1", PCF, InstrD, ValidD);
        end
    endtask

    task automatic test_wrap();
        PCSrcE = 1'b1; PCTargetE = 32'hFFFFFFFC;
        step();
        PCSrcE = 1'b0;
        checks++; if (PCF !== 32'hFFFFFFFC || MisalignD !== 1'b0) begin errors++; $display("FAIL wrap_pre got PCF=%h M=%b exp FFFFFFFC/0", PCF, MisalignD); end
        step();
        checks++; if (PCF !== 32'h0 || PCD !== 32'hFFFFFFFC || PCPlus4D !== 32'h0) begin
            errors++; $display("FAIL wrap got PCF=%h PCD=%h P4=%h exp 0/FFFFFFFC/0", PCF, PCD, PCPlus4D);
        end
        checks++; if (InstrD !== 32'h40100092 || ValidD !== 1'b1) begin errors++; $display("FAIL wrap_instr got=%h V=%b exp 40100092/1", InstrD, ValidD); end
        $display("wrap: PCF=%h PCD=%h InstrD=%h", PCF, PCD, InstrD);
    endtask

    initial begin
        test_reset();
        test_run();
        test_stall();
        test_redirect();
        test_redirect_over_stall();
        test_back_to_back();
        test_misalign();
        test_async_reset();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined RV32I core, directly upstream of the control unit's main decoder.
- Owns the program counter and drives the instruction-memory address.
- Registers the fetched instruction, PC and PC+4 into the IF/ID boundary; InstrD[6:0] feeds the decoder's op input.
- Supports hazard-unit stalls and branch redirects with bubble insertion.

Parameters:
- DATA_WIDTH, 32, instruction width in bits.
- ADDR_WIDTH, 32, PC and instruction-address width in bits.
- RESET_PC, 32'h00000000, PC value loaded on reset.
- BUBBLE_INSTR, 32'h00000000, instruction word injected on flush/reset. Opcode 0000000 decodes to all-zero controls: no RegWrite, no MemWrite, no Branch.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- StallF  input  1  hazard unit: hold PC and IF/ID contents.
- PCSrcE  input  1  branch/jump taken, resolved in EX: redirect fetch.
- PCTargetE  input  ADDR_WIDTH  redirect target address.
- ImemAddr  output  ADDR_WIDTH  instruction-memory address; equals PCF.
- ImemRdata  input  DATA_WIDTH  instruction word; combinational read of ImemAddr.
- PCF  output  ADDR_WIDTH  current fetch PC.
- InstrD  output  DATA_WIDTH  registered instruction to decode.
- PCD  output  ADDR_WIDTH  PC of InstrD.
- PCPlus4D  output  ADDR_WIDTH  PCD + 4.
- ValidD  output  1  InstrD is a real fetched instruction (0 = bubble).
- MisalignD  output  1  sticky flag: a redirect target had bits [1:0] != 0.

Behaviour:
- Reset (rst_n low, asynchronous, any cycle including mid-stall or mid-redirect):
  - PCF = RESET_PC, InstrD = BUBBLE_INSTR, PCD = 0, PCPlus4D = 0, ValidD = 0, MisalignD = 0.
  - On release, the first rising edge captures the instruction at RESET_PC; ValidD = 1 after that edge.
- PCPlus4F = PCF + 4, modulo 2^ADDR_WIDTH. 32'hFFFFFFFC wraps to 0 with no flag.
- Per-edge priority:
  1. PCSrcE = 1 (overrides StallF):
     - PCF <= {PCTargetE[ADDR_WIDTH-1:2], 2'b00}.
     - IF/ID <= bubble: InstrD = BUBBLE_INSTR, ValidD = 0, PCD and PCPlus4D hold.
     - If PCTargetE[1:0] != 0, MisalignD <= 1. It stays set until reset.
  2. Else if StallF = 1: PCF, InstrD, PCD, PCPlus4D and ValidD all hold.
  3. Else: PCF <= PCPlus4F, InstrD <= ImemRdata, PCD <= PCF, PCPlus4D <= PCPlus4F, ValidD <= 1.
- Latency: the instruction at address A appears on InstrD one cycle after PCF = A, absent stall or redirect.
- ImemAddr is combinational from PCF; there is no other combinational path from inputs to outputs.
- Redirect penalty:
  - The instruction fetched in the redirect cycle is discarded.
  - The target instruction appears on InstrD one edge after the redirect edge.
  - Any wrong-path instruction already in ID is the hazard unit's responsibility to flush downstream.
- Back-to-back redirects: each redirect applies; the last one wins. ValidD stays 0 until one non-redirect, non-stall edge occurs.
- A stall held for N cycles freezes all state for exactly N edges. There is no limit on N.

Test Plan:
- Reset then run, imem[i] = 32'h00100093 + i: PCF steps 0, 4, 8; InstrD = 32'h00100093 with PCD = 0 one cycle after reset release; ValidD = 1 from that edge onward.
- Pulse StallF for 3 cycles with PCF = 8: PCF stays 8; InstrD, PCD = 4 and ValidD hold for 3 edges; fetch resumes at 8 with no instruction lost or duplicated.
- PCSrcE = 1 with PCTargetE = 32'h40 and PCF = 12: next edge PCF = 32'h40, InstrD = 0, ValidD = 0; following edge InstrD = imem[16], PCD = 32'h40, ValidD = 1.
- PCSrcE = 1 and StallF = 1 in the same cycle with target 32'h80: redirect wins, PCF = 32'h80, ValidD = 0.
- Redirect to 32'h42: PCF = 32'h40, MisalignD = 1; it stays 1 after later normal redirects until rst_n is asserted.
- Assert rst_n low mid-stall at PCF = 32'h20: PCF, InstrD and ValidD clear immediately, without waiting for a clock edge. Force PCF = 32'hFFFFFFFC: next PCF = 0.
